// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer that sits between the UART receiver and the CPU
//   IO read mux. It absorbs bursts while the CPU polls, throttles the host
//   through CTS, and keeps a sticky overflow flag for dropped bytes.
//
// Parameters
//   DEPTH      entries; power of two, 4..256
//   HEADROOM   free entries still left when cts drops; 1..DEPTH-1
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high; clears all state
//   wr_valid   one-cycle strobe, one byte per high cycle
//   wr_data    received byte, qualified by wr_valid
//   rd_pop     consumes the head byte (ignored while empty)
//   rd_data    head byte, registered, first-word-fall-through
//   rd_valid   FIFO non-empty
//   cts        1 = host may send
//   overflow   sticky: a byte was dropped
//   ovf_clear  clears overflow (a same-cycle drop wins)
//   level      occupancy, only when UART_RX_FIFO_LEVEL_EN is defined
//
// Handshake: the write side has no back-pressure. Every cycle with wr_valid=1
// offers exactly one byte; it is stored when there is room (or a pop frees
// room in the same cycle) and dropped otherwise. A read happens in each cycle
// where rd_pop=1 and rd_valid=1; rd_data always shows the head while
// rd_valid=1.
//
// Optional feature macro: UART_RX_FIFO_LEVEL_EN
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int HEADROOM = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    input  logic                     rd_pop,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     cts,
    output logic                     overflow,
    input  logic                     ovf_clear
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] CTS_MAX  = PW'(DEPTH - HEADROOM - 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] count;
    logic [PW-1:0] count_next;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic          bypass;
    logic          head_load;

    always_comb begin
        count      = wptr - rptr;   // one extra pointer bit separates full from empty
        empty      = (count == '0);
        full       = (count == FULL_CNT);
        // A pop on a full FIFO frees the slot the incoming byte needs.
        push       = wr_valid & (~full | rd_pop);
        pop        = rd_pop & ~empty;
        drop       = wr_valid & full & ~rd_pop;
        rptr_next  = rptr + PW'(pop);
        count_next = count + PW'(push) - PW'(pop);
        // The incoming byte becomes the head directly when there is nothing
        // stored ahead of it after this cycle's pop.
        bypass     = push & (empty | (pop & (count == PW'(1))));
        // Otherwise the head only changes when a pop exposes a stored entry.
        head_load  = bypass | (pop & (count_next != '0));
    end

    // Storage array: no reset needed, pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            cts      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wptr     <= wptr + PW'(push);
            rptr     <= rptr_next;
            if (head_load) begin
                rd_data <= bypass ? wr_data : mem[rptr_next[AW-1:0]];
            end
            rd_valid <= (count_next != '0);
            cts      <= (count_next <= CTS_MAX);
            overflow <= drop | (overflow & ~ovf_clear);
        end
    end

`ifdef UART_RX_FIFO_LEVEL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
        end else begin
            level <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo (DEPTH=16, HEADROOM=4). A queue-based
//   reference model tracks the expected contents and flags every cycle; a
//   vector table and directed sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH    = 16;
  localparam int HEADROOM = 4;

  // clock / reset block
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_pop = 1'b0;
  logic       ovf_clear = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       cts;
  logic       overflow;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .HEADROOM(HEADROOM)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .rd_pop    (rd_pop),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .cts       (cts),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  // scoreboard / reference model state
  logic [7:0] exp_q[$];
  logic [7:0] m_data;
  logic       m_ovf;
  logic       m_cts;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one clock edge worth of behaviour, from queue rules.
  task automatic model_step(input logic r, input logic w, input logic [7:0] d,
                            input logic p, input logic c);
    int  n;
    logic do_pop, do_push, do_drop;
    if (r) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_cts  = 1'b0;
      m_data = 8'h00;
    end else begin
      n       = exp_q.size();
      do_pop  = p && (n > 0);
      do_push = w && ((n < DEPTH) || p);
      do_drop = w && (n == DEPTH) && !p;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
      m_ovf = do_drop || (m_ovf && !c);
      m_cts = (exp_q.size() <= DEPTH - HEADROOM - 1);
      if (exp_q.size() > 0) m_data = exp_q[0];
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after edge
  task automatic tick(input logic r, input logic w, input logic [7:0] d,
                      input logic p, input logic c);
    reset = r; wr_valid = w; wr_data = d; rd_pop = p; ovf_clear = c;
    @(posedge clk);
    model_step(r, w, d, p, c);
    #1;
    check("model_rd_valid", {31'd0, rd_valid}, {31'd0, (exp_q.size() != 0)});
    check("model_rd_data",  {24'd0, rd_data},  {24'd0, m_data});
    check("model_cts",      {31'd0, cts},      {31'd0, m_cts});
    check("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef UART_RX_FIFO_LEVEL_EN
    check("model_level",    32'(level),        32'(exp_q.size()));
`endif
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       pop;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_cts;
    logic       e_ovf;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [7:0] v;
    // rst wr d pop clr | valid data cts ovf
    vt[0]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h09, 1'b1, 1'b0};

    exp_q.delete();
    m_data = 8'h00; m_ovf = 1'b0; m_cts = 1'b0;

    // table-driven vectors: reset, single byte latency, bypass cases
    for (int i = 0; i < 14; i++) begin
      tick(vt[i].rst, vt[i].wr, vt[i].d, vt[i].pop, vt[i].clr);
      check($sformatf("vec%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vt[i].e_valid});
      check($sformatf("vec%0d_rd_data", i),  {24'd0, rd_data},  {24'd0, vt[i].e_data});
      check($sformatf("vec%0d_cts", i),      {31'd0, cts},      {31'd0, vt[i].e_cts});
      check($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vt[i].e_ovf});
    end

    // ordering: 16 pushes then 16 pops return 0x00..0x0F
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("order_head", {24'd0, rd_data}, 32'(i));
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("order_empty", {31'd0, rd_valid}, 32'd0);

    // pointer wrap: 40 bytes streamed through with a shallow backlog
    for (int k = 0; k < 40; k++) tick(1'b0, 1'b1, 8'(8'h80 + k), (k >= 3), 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // flow control: cts drops with 12 stored bytes, returns at 11
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    check("cts_at_11", {31'd0, cts}, 32'd1);
    tick(1'b0, 1'b1, 8'd11, 1'b0, 1'b0);
    check("cts_at_12", {31'd0, cts}, 32'd0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("cts_after_pop", {31'd0, cts}, 32'd1);

    // overflow: 17 pushes, 17th dropped; clear vs drop in same cycle
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    check("full_no_ovf", {31'd0, overflow}, 32'd0);
    tick(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    tick(1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // full push+pop: accepted, no overflow, new byte arrives last
    tick(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    check("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    check("full_pushpop_level", 32'(level), 32'd16);
`endif
    for (int i = 0; i < 16; i++) begin
      v = (i < 15) ? 8'(i + 1) : 8'hAA;
      check("full_drain_head", {24'd0, rd_data}, {24'd0, v});
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("full_drain_empty", {31'd0, rd_valid}, 32'd0);

    // randomized traffic against the model, with bursty and drain phases
    for (int n = 0; n < 3000; n++) begin
      int wp, pp;
      wp = ((n / 300) % 2 == 0) ? 80 : 30;
      pp = ((n / 300) % 2 == 0) ? 25 : 70;
      tick(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 99) < wp),
           8'($urandom),
           ($urandom_range(0, 99) < pp),
           ($urandom_range(0, 49) == 0));
    end

    // reset mid-burst drops everything
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'(i + 8'h30), 1'b0, 1'b0);
    tick(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    check("midreset_valid", {31'd0, rd_valid}, 32'd0);
    check("midreset_data", {24'd0, rd_data}, 32'd0);
    idle();
    check("post_reset_cts", {31'd0, cts}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
